// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU issue controller:
//   - datapath / register-file / opcode widths
//   - instruction field positions
//   - controller state encoding
//   - small decode helpers for the instruction word
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int CODE_W  = 5;
  localparam int NREG    = 8;
  localparam int REG_AW  = $clog2(NREG);
  localparam int INSTR_W = 16;

  // Instruction layout: [15:11] code, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] reserved
  localparam int CODE_MSB = 15;
  localparam int CODE_LSB = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RA_MSB   = 7;
  localparam int RA_LSB   = 5;
  localparam int RB_MSB   = 4;
  localparam int RB_LSB   = 2;
  localparam int RSVD_MSB = 1;
  localparam int RSVD_LSB = 0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic code_t instr_code(input logic [INSTR_W-1:0] ins);
    return ins[CODE_MSB:CODE_LSB];
  endfunction

  function automatic reg_addr_t instr_rd(input logic [INSTR_W-1:0] ins);
    return ins[RD_MSB:RD_LSB];
  endfunction

  function automatic reg_addr_t instr_ra(input logic [INSTR_W-1:0] ins);
    return ins[RA_MSB:RA_LSB];
  endfunction

  function automatic reg_addr_t instr_rb(input logic [INSTR_W-1:0] ins);
    return ins[RB_MSB:RB_LSB];
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// alu_ctrl_regfile
// NREG x DATA_W register file, asynchronously cleared.
//   clk, rst_n          : clock, active-low async reset (clears every entry)
//   we0/waddr0/wdata0   : primary write port (controller mux: writeback or host)
//   we1/waddr1/wdata1   : secondary write port, used only when a host write
//                         must land alongside a writeback to another entry;
//                         port 0 wins if both ever hit the same entry
//   ra_addr/ra_data     : operand A read (combinational)
//   rb_addr/rb_data     : operand B read (combinational)
//   hr_addr/hr_data     : host read (combinational)
// ---------------------------------------------------------------------------
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we0,
  input  reg_addr_t waddr0,
  input  data_t     wdata0,
  input  logic      we1,
  input  reg_addr_t waddr1,
  input  data_t     wdata1,
  input  reg_addr_t ra_addr,
  output data_t     ra_data,
  input  reg_addr_t rb_addr,
  output data_t     rb_data,
  input  reg_addr_t hr_addr,
  output data_t     hr_data
);

  data_t mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we0 && (waddr0 == reg_addr_t'(i))) begin
          mem_q[i] <= wdata0;
        end else if (we1 && (waddr1 == reg_addr_t'(i))) begin
          mem_q[i] <= wdata1;
        end
      end
    end
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
  assign hr_data = mem_q[hr_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issues register-to-register instructions to an external combinational ALU.
// Three-state sequence per instruction: IDLE (accept + operand fetch),
// EXEC (ALU evaluates, result captured), WB (result written back).
//   clk, rst_n           : clock, active-low async reset
//   instr_valid/ready    : instruction handshake; ready only in IDLE
//   instr                : {code[4:0], rd, ra, rb, 2'b reserved}
//   alu_a/alu_b/alu_code : registered ALU operands and opcode
//   alu_c/alu_ovf        : ALU result and overflow (combinational from alu_*)
//   done                 : one-cycle pulse after each writeback
//   result               : last written-back value
//   ovf_flag/ovf_clr     : sticky overflow and its clear (set wins)
//   host_we/addr/wdata   : host register write
//   host_rdata           : combinational read of reg[host_addr]
//   host_err             : pulses when a host write collides with writeback
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [CODE_W-1:0]  alu_code,
  input  logic [DATA_W-1:0]  alu_c,
  input  logic               alu_ovf,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic               ovf_flag,
  input  logic               ovf_clr,
  input  logic               host_we,
  input  logic [REG_AW-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic [DATA_W-1:0]  host_rdata,
  output logic               host_err
);

  state_e    state_q, state_d;
  reg_addr_t rd_q, rd_d;
  data_t     alu_a_q, alu_a_d;
  data_t     alu_b_q, alu_b_d;
  code_t     alu_code_q, alu_code_d;
  data_t     res_q, res_d;
  logic      ovf_q, ovf_d;
  data_t     result_q, result_d;
  logic      done_q, done_d;
  logic      ovf_flag_q, ovf_flag_d;

  logic      accept;
  logic      wb_fire;
  logic      host_hit_rd;

  logic      rf_we0, rf_we1;
  reg_addr_t rf_waddr0;
  data_t     rf_wdata0;
  data_t     rf_ra_data, rf_rb_data;

  // Reserved instruction bits carry no meaning here.
  logic [RSVD_MSB-RSVD_LSB:0] unused_rsvd;
  assign unused_rsvd = instr[RSVD_MSB:RSVD_LSB];

  assign accept      = instr_valid && (state_q == IDLE);
  assign wb_fire     = (state_q == WB);
  assign host_hit_rd = (host_addr == rd_q);

  // ---------------------------------------------------------------------
  // Register file write arbitration: writeback owns the primary port while
  // in WB; a host write to any other entry in that cycle takes the
  // secondary port so both land. A host write to rd during WB is dropped.
  // ---------------------------------------------------------------------
  assign rf_we0    = wb_fire || host_we;
  assign rf_waddr0 = wb_fire ? rd_q  : host_addr;
  assign rf_wdata0 = wb_fire ? res_q : host_wdata;
  assign rf_we1    = wb_fire && host_we && !host_hit_rd;

  alu_ctrl_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we0     (rf_we0),
    .waddr0  (rf_waddr0),
    .wdata0  (rf_wdata0),
    .we1     (rf_we1),
    .waddr1  (host_addr),
    .wdata1  (host_wdata),
    .ra_addr (instr_ra(instr)),
    .ra_data (rf_ra_data),
    .rb_addr (instr_rb(instr)),
    .rb_data (rf_rb_data),
    .hr_addr (host_addr),
    .hr_data (host_rdata)
  );

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    rd_d       = rd_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_code_d = alu_code_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    done_d     = 1'b0;
    ovf_flag_d = ovf_flag_q;

    // Operands are sampled from the register file before this edge's
    // writes land, so a same-cycle host write to ra/rb is not seen.
    if (accept) begin
      rd_d       = instr_rd(instr);
      alu_a_d    = rf_ra_data;
      alu_b_d    = rf_rb_data;
      alu_code_d = instr_code(instr);
    end

    if (state_q == EXEC) begin
      res_d = alu_c;
      ovf_d = alu_ovf;
    end

    if (wb_fire) begin
      result_d = res_q;
      done_d   = 1'b1;
    end

    // Clear first, then set, so a writeback overflow wins over ovf_clr.
    if (ovf_clr) begin
      ovf_flag_d = 1'b0;
    end
    if (wb_fire && ovf_q) begin
      ovf_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_code_q <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_code_q <= alu_code_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      done_q     <= done_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign instr_ready = (state_q == IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_code    = alu_code_q;
  assign done        = done_q;
  assign result      = result_q;
  assign ovf_flag    = ovf_flag_q;
  assign host_err    = wb_fire && host_we && host_hit_rd;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_code;
  logic [15:0] alu_c;
  logic        alu_ovf;
  logic        done;
  logic [15:0] result;
  logic        ovf_flag;
  logic        ovf_clr;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_err;

  int total;
  int bad;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_code    (alu_code),
    .alu_c       (alu_c),
    .alu_ovf     (alu_ovf),
    .done        (done),
    .result      (result),
    .ovf_flag    (ovf_flag),
    .ovf_clr     (ovf_clr),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_err    (host_err)
  );

  always #5 clk = ~clk;

  // ALU model: 0 add (ovf = carry), 1 sub (ovf = borrow), 2 and, 3 xor
  always_comb begin
    alu_c   = 16'h0000;
    alu_ovf = 1'b0;
    case (alu_code)
      5'd0: {alu_ovf, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      5'd1: {alu_ovf, alu_c} = {1'b0, alu_a} - {1'b0, alu_b};
      5'd2: alu_c = alu_a & alu_b;
      5'd3: alu_c = alu_a ^ alu_b;
      default: ;
    endcase
  end

  function automatic logic [15:0] mk(input logic [4:0] code, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {code, rd, ra, rb, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    host_addr = addr;
    #1;
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_we    = 1'b0;
  endtask

  // Accept at the next edge, then advance to just after accept+2.
  task automatic issue(input logic [15:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
  endtask

  // Only called while rst_n is held low, so crossing edges is harmless.
  task automatic check_reset_state(input string tag);
    host_we = 1'b0;
    check({tag, "_ready"},    32'(instr_ready), 32'h1);
    check({tag, "_done"},     32'(done),        32'h0);
    check({tag, "_result"},   32'(result),      32'h0);
    check({tag, "_alu_a"},    32'(alu_a),       32'h0);
    check({tag, "_alu_b"},    32'(alu_b),       32'h0);
    check({tag, "_alu_code"}, 32'(alu_code),    32'h0);
    check({tag, "_ovf_flag"}, 32'(ovf_flag),    32'h0);
    check({tag, "_host_err"}, 32'(host_err),    32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_check($sformatf("%s_r%0d", tag, i), 3'(i), 16'h0000);
    end
  endtask

  logic [15:0] b2b_ins [3];
  logic [15:0] b2b_res [3];
  int          done_cnt;

  initial begin
    clk = 1'b0; rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0;
    ovf_clr = 1'b0; host_we = 1'b0; host_addr = 3'd0; host_wdata = 16'h0;
    total = 0; bad = 0;

    // ---------------- reset state ----------------
    #2;
    check_reset_state("rst0");
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- add path ----------------
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    rd_check("host_r1", 3'd1, 16'h0003);
    instr = mk(5'd0, 3'd3, 3'd1, 3'd2);
    instr_valid = 1'b1;
    check("ready_idle", 32'(instr_ready), 32'h1);
    tick();
    instr_valid = 1'b0;
    check("add_alu_a",    32'(alu_a),       32'h3);
    check("add_alu_b",    32'(alu_b),       32'h5);
    check("add_alu_code", 32'(alu_code),    32'h0);
    check("add_ready_n1", 32'(instr_ready), 32'h0);
    check("add_done_n1",  32'(done),        32'h0);
    tick();
    check("add_ready_n2", 32'(instr_ready), 32'h0);
    check("add_done_n2",  32'(done),        32'h0);
    tick();
    check("add_done",     32'(done),        32'h1);
    check("add_result",   32'(result),      32'h8);
    check("add_ready_n3", 32'(instr_ready), 32'h1);
    rd_check("add_r3", 3'd3, 16'h0008);
    tick();
    check("add_done_pulse", 32'(done), 32'h0);

    // ---------------- overflow ----------------
    host_write(3'd4, 16'hFFFF);
    host_write(3'd5, 16'h0002);
    issue(mk(5'd0, 3'd6, 3'd4, 3'd5));
    check("ovf_result", 32'(result),   32'h1);
    check("ovf_set",    32'(ovf_flag), 32'h1);
    issue(mk(5'd3, 3'd7, 3'd1, 3'd2));
    check("xor_result", 32'(result),   32'h6);
    check("ovf_sticky", 32'(ovf_flag), 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_flag), 32'h0);
    instr = mk(5'd0, 3'd6, 3'd4, 3'd4);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    ovf_clr = 1'b1;            // WB cycle: set must win
    tick();
    ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf_flag), 32'h1);
    check("ovf2_result",  32'(result),   32'hFFFE);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr2", 32'(ovf_flag), 32'h0);

    // ---------------- back-to-back ----------------
    b2b_ins[0] = mk(5'd1, 3'd0, 3'd2, 3'd1);  // r0 = 5 - 3 = 2
    b2b_ins[1] = mk(5'd0, 3'd1, 3'd0, 3'd2);  // r1 = 2 + 5 = 7
    b2b_ins[2] = mk(5'd0, 3'd2, 3'd1, 3'd0);  // r2 = 7 + 2 = 9
    b2b_res[0] = 16'h0002;
    b2b_res[1] = 16'h0007;
    b2b_res[2] = 16'h0009;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if ((c % 3 == 0) && (c < 9)) begin
        instr = b2b_ins[c / 3];
        instr_valid = 1'b1;
      end
      if (c == 9) instr_valid = 1'b0;
      check($sformatf("b2b_ready_c%0d", c), 32'(instr_ready), 32'((c % 3) == 0));
      check($sformatf("b2b_done_c%0d", c),  32'(done), 32'((c > 0) && ((c % 3) == 0)));
      if (done) done_cnt++;
      if ((c > 0) && ((c % 3) == 0)) begin
        check($sformatf("b2b_result_c%0d", c), 32'(result), 32'(b2b_res[c / 3 - 1]));
      end
      tick();
    end
    check("b2b_done_count", 32'(done_cnt), 32'd3);
    rd_check("b2b_r0", 3'd0, 16'h0002);
    rd_check("b2b_r1", 3'd1, 16'h0007);
    rd_check("b2b_r2", 3'd2, 16'h0009);

    // ---------------- collision ----------------
    tick();
    instr = mk(5'd2, 3'd3, 3'd1, 3'd2);       // r3 = 7 & 9 = 1
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    host_we = 1'b1; host_addr = 3'd3; host_wdata = 16'hBEEF;
    #1;
    check("coll_host_err", 32'(host_err), 32'h1);
    tick();
    host_we = 1'b0;
    check("coll_host_err_pulse", 32'(host_err), 32'h0);
    check("coll_done",   32'(done),   32'h1);
    check("coll_result", 32'(result), 32'h1);
    rd_check("coll_r3", 3'd3, 16'h0001);

    instr = mk(5'd3, 3'd4, 3'd3, 3'd1);       // r4 = 1 ^ 7 = 6
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    host_we = 1'b1; host_addr = 3'd5; host_wdata = 16'h1234;
    #1;
    check("other_host_err", 32'(host_err), 32'h0);
    tick();
    host_we = 1'b0;
    check("other_done", 32'(done), 32'h1);
    rd_check("other_r4", 3'd4, 16'h0006);
    rd_check("other_r5", 3'd5, 16'h1234);

    // Host write to ra/rb in the accept cycle: old operands used, new value lands.
    tick();
    instr = mk(5'd0, 3'd7, 3'd5, 3'd5);
    instr_valid = 1'b1;
    host_we = 1'b1; host_addr = 3'd5; host_wdata = 16'h0001;
    tick();
    instr_valid = 1'b0;
    host_we = 1'b0;
    check("acc_wr_alu_a", 32'(alu_a), 32'h1234);
    check("acc_wr_alu_b", 32'(alu_b), 32'h1234);
    rd_check("acc_wr_r5", 3'd5, 16'h0001);
    tick();
    tick();
    check("acc_wr_result", 32'(result), 32'h2468);
    rd_check("acc_wr_r7", 3'd7, 16'h2468);

    // ---------------- abort ----------------
    tick();
    instr = mk(5'd0, 3'd0, 3'd1, 3'd2);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("abort_in_exec", 32'(instr_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    tick();
    check("abort_done_rst", 32'(done), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort_done_k%0d", k),  32'(done),        32'h0);
      check($sformatf("abort_ready_k%0d", k), 32'(instr_ready), 32'h1);
    end
    rd_check("abort_r0", 3'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
